stream_fifo: RTL and testbench
==============================

Name: stream_fifo

Overview:
Parametrised single-clock FIFO for buffering feature-map and weight streams between CNN pipeline stages (line buffers, PE array feeders, output collectors).
- Generalised in width and depth.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, a first-word-fall-through (FWFT) mode, synchronous flush, and sticky overflow/underflow error flags.
- Storage is a power-of-two circular buffer addressed by wrap-bit pointers.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 256, number of entries; must be a power of two and at least 4
ADDR_W, 8, log2(DEPTH); must be consistent with DEPTH
AF_TH, 252, almost_full asserts when count >= AF_TH
AE_TH, 4, almost_empty asserts when count <= AE_TH
FWFT, 0, 0 = standard read (1-cycle latency); 1 = first-word-fall-through

Ports:
w_clk  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous flush; same effect as reset except err flags are retained
w_en  in  1  write request
din  in  DATA_W  write data
r_en  in  1  read request (pop)
dout  out  DATA_W  read data
dout_valid  out  1  dout holds valid data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_TH
almost_empty  out  1  count <= AE_TH
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset and clear:
  - reset (sampled on rising w_clk): wptr = rptr = 0, count = 0, dout = 0, dout_valid = 0, overflow = underflow = 0. Consequently empty = 1, full = 0, almost_empty = 1, almost_full = (AF_TH == 0).
  - clear: identical, but overflow/underflow keep their values.
  - reset or clear asserted mid-operation discards all contents and any same-cycle w_en/r_en. Memory contents are not cleared.
- Pointers:
  - wptr and rptr are ADDR_W+1 bits; the low ADDR_W bits address memory, the MSB is the wrap bit.
  - full = MSBs differ and low bits equal. empty = pointers equal.
  - Pointers wrap naturally modulo 2*DEPTH.
- Write: accepted iff w_en & ~full at the clock edge. Memory[wptr] <= din, then wptr increments.
- Read: accepted iff r_en & ~empty at the clock edge, then rptr increments.
- Flags evaluate against pre-edge state:
  - A write while full is rejected even if a read is accepted the same cycle.
  - A read while empty is rejected even if a write is accepted the same cycle.
  - Rejected write sets overflow; rejected read sets underflow. Both stay set until reset.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- count: +1 on write only, -1 on read only.
- Flag timing: full, empty, almost_full and almost_empty are combinational from count and pointers, so they reflect the new state one cycle after the accepting edge.
- FWFT = 0:
  - On an accepted read, dout <= mem[rptr] and dout_valid = 1 for exactly the next cycle. Otherwise dout_valid = 0 and dout holds its last value.
  - Back-to-back reads give one word per cycle.
- FWFT = 1:
  - dout = mem[rptr] whenever ~empty; dout_valid = ~empty.
  - r_en acknowledges (pops) the displayed word.
  - A word written into an empty FIFO appears on dout one cycle after the write edge; there is no same-cycle bypass.
- Throughput: one write and one read per cycle sustained, with no bubbles at pointer wrap.

Decomposition:
- Shared package / header `cnn_fifo_pkg` holds:
  - a clog2 helper for ADDR_W derivation checks,
  - FIFO mode constants (FIFO_STD = 0, FIFO_FWFT = 1),
  - the default DATA_W = 8 used across CNN stream blocks.
- One sub-module: `fifo_mem_2p`, a simple dual-port RAM with synchronous write (port A) and a read port that is registered for STD or combinational for FWFT, selected by a parameter. Written so it infers block RAM for large DEPTH.
- Pointer, count and flag logic stays in stream_fifo.

Test Plan:
1. DEPTH=8, DATA_W=8, FWFT=0. Reset, write 0x11..0x18 on 8 consecutive cycles -> full=1 and count=8 after the 8th edge. A 9th write of 0xFF -> overflow=1, count stays 8. Read 8 words -> dout 0x11..0x18 with dout_valid one cycle after each r_en; empty=1 afterwards.
2. Wrap-around: DEPTH=8, repeatedly write 3 words and read 3 words for 40 cycles with incrementing data -> output sequence is exactly the input sequence, count never exceeds 3, no error flags.
3. Simultaneous read and write at count=4 for 20 cycles -> count stays 4, data order preserved. With full, w_en & r_en together -> read accepted, write rejected, overflow=1, count=7.
4. FWFT=1: write 0xA5 into an empty FIFO -> the next cycle dout=0xA5 and dout_valid=1 without r_en. Pulse r_en -> empty=1 and dout_valid=0 the following cycle. r_en while empty -> underflow=1.
5. Thresholds, AF_TH=6, AE_TH=2: fill from 0 to 8 -> almost_empty drops when count reaches 3, almost_full rises at count 6.
6. Fill to 5, pulse clear -> count=0, empty=1, overflow still 1 from an earlier event. Then pulse reset -> overflow=0.

Source files
------------

// File: rtl/cnn_fifo_pkg.sv
// Shared definitions for CNN stream buffering blocks: default word width,
// FIFO read-mode selectors and elaboration-time helpers.
package cnn_fifo_pkg;

  localparam int unsigned CNN_DATA_W = 8;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port RAM: synchronous write on port A; read port is registered
// (standard mode) or combinational (first-word-fall-through mode).
module fifo_mem_2p
  import cnn_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = CNN_DATA_W,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned MODE   = FIFO_STD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (MODE == FIFO_FWFT) begin : g_comb_rd
      logic unused_ctrl;
      assign unused_ctrl = ^{rst, re};
      assign rdata = mem[raddr];
    end else begin : g_reg_rd
      // Output register carries the flush reset so dout returns to zero.
      always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end
  endgenerate

endmodule

// File: rtl/stream_fifo.sv
// Single-clock stream FIFO with wrap-bit pointers, occupancy count,
// almost-full/empty thresholds, optional FWFT output and sticky error flags.
module stream_fifo
  import cnn_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = CNN_DATA_W,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned AF_TH  = 252,
  parameter int unsigned AE_TH  = 4,
  parameter int unsigned FWFT   = FIFO_STD
) (
  input  logic              w_clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              w_en,
  input  logic [DATA_W-1:0] din,
  input  logic              r_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  generate
    if (!is_pow2(DEPTH) || DEPTH < 4 || ADDR_W != clog2(DEPTH)) begin : g_bad_params
      $error("stream_fifo: DEPTH must be a power of two >= 4 and ADDR_W = log2(DEPTH)");
    end
  endgenerate

  localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_TH);
  localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(AE_TH);

  logic [ADDR_W:0]   wptr, rptr;
  logic              wr_acc, rd_acc, flush;
  logic [DATA_W-1:0] mem_rdata;

  assign flush = reset | clear;

  always_comb begin
    full         = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    empty        = (wptr == rptr);
    count        = wptr - rptr;
    almost_full  = (count >= AF_LVL);
    almost_empty = (count <= AE_LVL);
    wr_acc       = w_en & ~full;
    rd_acc       = r_en & ~empty;
  end

  always_ff @(posedge w_clk) begin
    if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
    end
  end

  // Error flags survive clear; a flushed cycle's requests never count as rejected.
  always_ff @(posedge w_clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!clear) begin
      if (w_en & full)  overflow  <= 1'b1;
      if (r_en & empty) underflow <= 1'b1;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .MODE   (FWFT)
  ) u_mem (
    .clk   (w_clk),
    .rst   (flush),
    .we    (wr_acc & ~flush),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (din),
    .re    (rd_acc & ~flush),
    .raddr (rptr[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft_out
      assign dout_valid = ~empty;
      assign dout       = empty ? '0 : mem_rdata;
    end else begin : g_std_out
      always_ff @(posedge w_clk) begin
        if (flush) dout_valid <= 1'b0;
        else       dout_valid <= rd_acc;
      end
      assign dout = mem_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: a standard and an FWFT instance share the
// same stimulus and are compared every cycle against a queue model.
module tb_stream_fifo;

  logic       w_clk = 1'b0;
  logic       reset, clear, w_en, r_en;
  logic [7:0] din;

  logic [7:0] s_dout, f_dout;
  logic       s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0] s_count, f_count;

  int errors = 0;
  int checks = 0;

  always #5 w_clk = ~w_clk;

  stream_fifo #(
    .DATA_W(8), .DEPTH(8), .ADDR_W(3), .AF_TH(6), .AE_TH(2), .FWFT(0)
  ) dut_std (
    .w_clk(w_clk), .reset(reset), .clear(clear), .w_en(w_en), .din(din),
    .r_en(r_en), .dout(s_dout), .dout_valid(s_valid), .full(s_full),
    .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  stream_fifo #(
    .DATA_W(8), .DEPTH(8), .ADDR_W(3), .AF_TH(6), .AE_TH(2), .FWFT(1)
  ) dut_fw (
    .w_clk(w_clk), .reset(reset), .clear(clear), .w_en(w_en), .din(din),
    .r_en(r_en), .dout(f_dout), .dout_valid(f_valid), .full(f_full),
    .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue model of an 8-entry FIFO.
  byte unsigned q[$];
  logic       m_ovf = 1'b0, m_unf = 1'b0, m_valid = 1'b0;
  logic [7:0] m_dout = 8'h00;
  bit         armed = 1'b0;

  always @(posedge w_clk) begin : model
    bit wa, ra;
    if (reset || clear) begin
      q.delete();
      m_dout  = 8'h00;
      m_valid = 1'b0;
      if (reset) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
    end else begin
      wa = w_en && (q.size() < 8);
      ra = r_en && (q.size() > 0);
      if (w_en && !wa) m_ovf = 1'b1;
      if (r_en && !ra) m_unf = 1'b1;
      m_valid = ra;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(din);
    end
  end

  always @(negedge w_clk) begin : compare
    int n;
    if (armed) begin
      n = q.size();
      chk("std_count", 32'(s_count), 32'(n));
      chk("fw_count",  32'(f_count), 32'(n));
      chk("std_empty", 32'(s_empty), 32'(n == 0));
      chk("fw_empty",  32'(f_empty), 32'(n == 0));
      chk("std_full",  32'(s_full),  32'(n == 8));
      chk("fw_full",   32'(f_full),  32'(n == 8));
      chk("std_af",    32'(s_af),    32'(n >= 6));
      chk("fw_af",     32'(f_af),    32'(n >= 6));
      chk("std_ae",    32'(s_ae),    32'(n <= 2));
      chk("fw_ae",     32'(f_ae),    32'(n <= 2));
      chk("std_ovf",   32'(s_ovf),   32'(m_ovf));
      chk("fw_ovf",    32'(f_ovf),   32'(m_ovf));
      chk("std_unf",   32'(s_unf),   32'(m_unf));
      chk("fw_unf",    32'(f_unf),   32'(m_unf));
      chk("std_valid", 32'(s_valid), 32'(m_valid));
      chk("std_dout",  32'(s_dout),  32'(m_dout));
      chk("fw_valid",  32'(f_valid), 32'(n > 0));
      chk("fw_dout",   32'(f_dout),  (n > 0) ? 32'(q[0]) : 32'h0);
    end
  end

  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic rs = 1'b0, input logic cl = 1'b0);
    w_en  = w;
    din   = d;
    r_en  = r;
    reset = rs;
    clear = cl;
    @(posedge w_clk);
    #1;
  endtask

  initial begin
    logic [7:0] wdat, rexp;
    reset = 1'b1; clear = 1'b0; w_en = 1'b0; r_en = 1'b0; din = 8'h00;
    step(0, 8'h00, 0, 1);
    armed = 1'b1;
    step(0, 8'h00, 0, 1);

    chk("rst_count", 32'(s_count), 0);
    chk("rst_empty", 32'(s_empty), 1);
    chk("rst_full",  32'(s_full), 0);
    chk("rst_ae",    32'(s_ae), 1);
    chk("rst_af",    32'(s_af), 0);
    chk("rst_dout",  32'(s_dout), 0);
    chk("rst_valid", 32'(s_valid), 0);
    chk("rst_fw_valid", 32'(f_valid), 0);

    // Fill, overflow, drain
    for (int i = 0; i < 8; i++) step(1, 8'(8'h11 + i), 0);
    chk("t1_full",  32'(s_full), 1);
    chk("t1_count", 32'(s_count), 8);
    step(1, 8'hFF, 0);
    chk("t1_ovf",   32'(s_ovf), 1);
    chk("t1_count_ovf", 32'(s_count), 8);
    for (int i = 0; i < 8; i++) begin
      step(0, 8'h00, 1);
      chk("t1_rvalid", 32'(s_valid), 1);
      chk("t1_rdata",  32'(s_dout), 32'(8'h11 + i));
    end
    step(0, 8'h00, 0);
    chk("t1_valid_drop", 32'(s_valid), 0);
    chk("t1_empty", 32'(s_empty), 1);
    chk("t1_dout_hold", 32'(s_dout), 32'h18);

    // Wrap-around with 3-in / 3-out bursts
    step(0, 8'h00, 0, 1);
    wdat = 8'h30; rexp = 8'h30;
    for (int c = 0; c < 40; c++) begin
      if ((c % 6) < 3) begin
        step(1, wdat, 0);
        wdat++;
      end else begin
        step(0, 8'h00, 1);
        chk("t2_rdata", 32'(s_dout), 32'(rexp));
        rexp++;
      end
      chk("t2_count_max", 32'(s_count <= 4'd3), 1);
    end
    chk("t2_ovf", 32'(s_ovf), 0);
    chk("t2_unf", 32'(s_unf), 0);

    // Simultaneous read/write at count 4, then at full
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(8'h44 + i), 1);
      chk("t3_count", 32'(s_count), 4);
      chk("t3_rdata", 32'(s_dout), 32'(8'h40 + i));
    end
    for (int i = 0; i < 4; i++) step(1, 8'(8'h58 + i), 0);
    chk("t3_full", 32'(s_full), 1);
    step(1, 8'hEE, 1);
    chk("t3_count_rw_full", 32'(s_count), 7);
    chk("t3_ovf", 32'(s_ovf), 1);
    chk("t3_rdata_full", 32'(s_dout), 32'h54);

    // Clear keeps error flags, reset drops them
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    chk("t6_count5", 32'(s_count), 5);
    step(1, 8'h99, 0, 0, 1);
    chk("t6_clr_count", 32'(s_count), 0);
    chk("t6_clr_empty", 32'(s_empty), 1);
    chk("t6_clr_ovf",   32'(s_ovf), 1);
    chk("t6_clr_dout",  32'(s_dout), 0);
    step(0, 8'h00, 0, 1);
    chk("t6_rst_ovf", 32'(s_ovf), 0);

    // First-word-fall-through behaviour
    step(1, 8'hA5, 0);
    chk("t4_fw_dout",  32'(f_dout), 32'hA5);
    chk("t4_fw_valid", 32'(f_valid), 1);
    chk("t4_std_valid", 32'(s_valid), 0);
    step(0, 8'h00, 0);
    chk("t4_fw_hold", 32'(f_dout), 32'hA5);
    step(0, 8'h00, 1);
    chk("t4_fw_pop_valid", 32'(f_valid), 0);
    chk("t4_fw_pop_empty", 32'(f_empty), 1);
    chk("t4_std_pop", 32'(s_dout), 32'hA5);
    step(0, 8'h00, 1);
    chk("t4_unf", 32'(f_unf), 1);
    step(1, 8'h5A, 1);
    chk("t4_rw_empty_count", 32'(f_count), 1);
    chk("t4_rw_empty_dout",  32'(f_dout), 32'h5A);
    step(1, 8'h77, 1, 1);
    chk("t4_rst_mid_count", 32'(f_count), 0);
    chk("t4_rst_mid_unf",   32'(f_unf), 0);

    // Threshold crossings while filling
    for (int i = 1; i <= 8; i++) begin
      step(1, 8'(i), 0);
      chk("t5_count", 32'(s_count), 32'(i));
      chk("t5_ae", 32'(s_ae), 32'(i <= 2));
      chk("t5_af", 32'(s_af), 32'(i >= 6));
    end
    step(0, 8'h00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
